// File: rtl/wide_alu_pipe.sv
// wide_alu_pipe: wide-datapath ALU with a configurable-depth, elastic output
// pipeline (valid/ready at both ends), carry/borrow flag, pass-through tag and
// a completed-operation counter.
module wide_alu_pipe #(
    parameter int W      = 512,
    parameter int STAGES = 2,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [W-1:0]     rs1,
    input  logic [W-1:0]     rs2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     res,
    output logic             carry,
    output logic [TAG_W-1:0] tag_out,
    output logic [31:0]      ops_done
);

    localparam int SHW = $clog2(W);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_SRA  = 3'd4,
        OP_FOLD = 3'd5,
        OP_ROTL = 3'd6,
        OP_LTU  = 3'd7
    } op_e;

    if (((W % 32) != 0) || (W < 64)) begin : g_bad_w
        $error("wide_alu_pipe: W must be a multiple of 32 and at least 64");
    end
    if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
        $error("wide_alu_pipe: STAGES must be in 1..4");
    end

    logic [SHW-1:0]   w_sh;
    logic [W:0]       w_sum;
    logic [W:0]       w_diff;
    logic [2*W-1:0]   w_rot;
    logic [31:0]      w_fold;
    logic [W-1:0]     w_alu_res;
    logic             w_alu_carry;
    logic [STAGES-1:0] w_load;

    logic [STAGES-1:0] r_valid;
    logic [W-1:0]      r_res   [STAGES];
    logic              r_carry [STAGES];
    logic [TAG_W-1:0]  r_tag   [STAGES];
    logic [31:0]       r_ops_done;

    // ALU: result and carry/borrow for the op currently offered at the input
    always_comb begin
        w_sh        = rs2[SHW-1:0];
        w_sum       = {1'b0, rs1} + {1'b0, rs2};
        w_diff      = {1'b0, rs1} - {1'b0, rs2};
        // rotate = upper half of the doubled operand shifted left; sh=0 yields rs1
        w_rot       = {rs1, rs1} << w_sh;
        w_fold      = '0;
        for (int unsigned k = 0; k < W / 32; k++) begin
            w_fold = w_fold ^ rs1[k*32 +: 32];
        end
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        case (op_e'(op))
            OP_ADD: begin
                w_alu_res   = w_sum[W-1:0];
                w_alu_carry = w_sum[W];
            end
            OP_SUB: begin
                w_alu_res   = w_diff[W-1:0];
                w_alu_carry = w_diff[W];
            end
            OP_SHL:  w_alu_res = rs1 << w_sh;
            OP_SHR:  w_alu_res = rs1 >> w_sh;
            OP_SRA:  w_alu_res = $signed(rs1) >>> w_sh;
            OP_FOLD: w_alu_res[31:0] = w_fold;
            OP_ROTL: w_alu_res = w_rot[2*W-1:W];
            OP_LTU:  w_alu_res[0] = (rs1 < rs2);
            default: w_alu_res = '0;
        endcase
    end

    // Stage load enables: stage i may load when any stage from i onward is
    // empty, or the output is being consumed (flattened form of the ready chain)
    always_comb begin
        w_load = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            w_load[i] = out_ready;
            for (int unsigned j = i; j < STAGES; j++) begin
                if (!r_valid[j]) begin
                    w_load[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = w_load[0];

    // Pipeline stages: stage 0 captures the ALU result, later stages shift
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_res[i]   <= '0;
                r_carry[i] <= 1'b0;
                r_tag[i]   <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_res[0]   <= w_alu_res;
                    r_carry[0] <= w_alu_carry;
                    r_tag[0]   <= tag_in;
                end
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_res[i]   <= r_res[i-1];
                        r_carry[i] <= r_carry[i-1];
                        r_tag[i]   <= r_tag[i-1];
                    end
                end
            end
        end
    end

    // Completed-op counter: one count per output handshake, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ops_done <= '0;
        end else if (r_valid[STAGES-1] && out_ready) begin
            r_ops_done <= r_ops_done + 32'd1;
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign res       = r_res[STAGES-1];
    assign carry     = r_carry[STAGES-1];
    assign tag_out   = r_tag[STAGES-1];
    assign ops_done  = r_ops_done;

endmodule

// File: tb/tb_wide_alu_pipe.sv
// Directed self-checking bench for wide_alu_pipe (W=512, STAGES=2, TAG_W=8).
module tb_wide_alu_pipe;

    localparam int W = 512;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [7:0]   tag_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         carry;
    logic [7:0]   tag_out;
    logic [31:0]  ops_done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_done = 0;

    wide_alu_pipe #(.W(W), .STAGES(2), .TAG_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .carry(carry), .tag_out(tag_out),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with out_ready high and check the result after two stages
    task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [7:0] t,
                          input logic [W-1:0] er, input logic ec);
        op = o; rs1 = a; rs2 = b; tag_in = t; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({nm, "_in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        check({nm, "_not_yet"}, out_valid, 0);
        step();
        check({nm, "_valid"}, out_valid, 1);
        check({nm, "_res"}, res, er);
        check({nm, "_carry"}, carry, ec);
        check({nm, "_tag"}, tag_out, t);
        step();
        exp_done++;
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] msb;
    logic [W-1:0] one;
    logic [W-1:0] fold_in;
    logic [W-1:0] held_res;
    logic [W-1:0] v5;
    logic [W-1:0] v7;
    int           s_next;
    int           e_next;
    bit           fire_in;
    bit           stale;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ones    = '1;
        one     = '0; one[0] = 1'b1;
        msb     = '0; msb[W-1] = 1'b1;
        v5      = W'(5);
        v7      = W'(7);
        fold_in = '0;
        fold_in[31:0]  = 32'hffffc7da;
        fold_in[63:32] = 32'habab1212;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; rs1 = '0; rs2 = '0; tag_in = '0;
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_res", res, 0);
        check("rst_carry", carry, 0);
        check("rst_tag", tag_out, 0);
        check("rst_ops_done", ops_done, 0);
        check("rst_in_ready", in_ready, 1);

        run_op("add_carry", 3'd0, ones, one, 8'hA1, '0, 1'b1);
        run_op("add_nocarry", 3'd0, v5, v7, 8'hA2, W'(12), 1'b0);
        run_op("sub_borrow", 3'd1, v5, v7, 8'hA3, ones - one, 1'b1);
        run_op("sub_noborrow", 3'd1, v7, v5, 8'hA4, W'(2), 1'b0);
        run_op("ltu_true", 3'd7, v5, v7, 8'hA5, one, 1'b0);
        run_op("ltu_false", 3'd7, v7, v5, 8'hA6, '0, 1'b0);
        run_op("sra_511", 3'd4, msb, W'(511), 8'hA7, ones, 1'b0);
        run_op("shr_511", 3'd3, msb, W'(511), 8'hA8, one, 1'b0);
        run_op("rotl_1", 3'd6, msb, W'(1), 8'hA9, one, 1'b0);
        run_op("rotl_0", 3'd6, fold_in, '0, 8'hAA, fold_in, 1'b0);
        run_op("shl_4", 3'd2, one, W'(4), 8'hAB, W'(16), 1'b0);
        run_op("shl_upper_ign", 3'd2, one, W'(32'h0002_0004), 8'hAC, W'(16), 1'b0);
        run_op("fold", 3'd5, fold_in, '0, 8'hAD, W'(32'h5454d5c8), 1'b0);
        check("ops_done_directed", ops_done, W'(exp_done));

        // Reset with two ops in flight
        out_ready = 1'b0;
        op = 3'd0; rs1 = v5; rs2 = v7; in_valid = 1'b1;
        tag_in = 8'h55; step();
        tag_in = 8'h66; step();
        in_valid = 1'b0;
        check("pre_rst_full", out_valid, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_ops_done", ops_done, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_res", res, 0);
        out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) stale = 1'b1;
        end
        check("midrst_no_stale", stale, 0);

        // Backpressure: only two ops fit, output held stable
        out_ready = 1'b0;
        op = 3'd0; rs2 = '0; in_valid = 1'b1;
        tag_in = 8'd1; rs1 = W'(1); #1;
        check("bp_acc1", in_ready, 1);
        step();
        tag_in = 8'd2; rs1 = W'(2); #1;
        check("bp_acc2", in_ready, 1);
        step();
        tag_in = 8'd3; rs1 = W'(3); #1;
        check("bp_full_ready", in_ready, 0);
        check("bp_full_valid", out_valid, 1);
        check("bp_head_tag", tag_out, 1);
        check("bp_head_res", res, W'(1));
        held_res = res;
        step();
        check("bp_still_full", in_ready, 0);
        step();
        check("bp_hold_tag", tag_out, 1);
        check("bp_hold_res", res, held_res);
        check("bp_hold_carry", carry, 0);

        // Drain with out_ready high, offering tag 3 then 4
        out_ready = 1'b1;
        s_next = 3;
        e_next = 1;
        for (int c = 0; c < 20 && e_next <= 4; c++) begin
            in_valid = (s_next <= 4);
            tag_in   = 8'(s_next);
            rs1      = W'(s_next);
            #1;
            fire_in = in_valid && in_ready;
            if (out_valid) begin
                check("bp_drain_tag", tag_out, W'(e_next));
                check("bp_drain_res", res, W'(e_next));
                e_next++;
            end
            step();
            if (fire_in) s_next++;
        end
        in_valid = 1'b0;
        check("bp_all_out", W'(e_next), W'(5));
        check("bp_ops_done", ops_done, W'(4));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
